// File: rtl/ula_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ula_sequencer
//  Purpose  : Front-end controller for the ULA. Synchronises, debounces and
//             edge-detects the active-low KEY pushbuttons, holds operands a/b
//             and opcode op, and runs one SETTLE/CAPTURE sequence per execute
//             press, latching result1/result2 into res1_q/res2_q.
//  Ports    : CLOCK_50 - system clock (rising edge)
//             reset    - synchronous active-high reset
//             KEY[3:0] - raw buttons, active-low: [0] op+1, [1] b+1,
//                        [2] a+1, [3] execute
//             result1/result2 - ULA outputs (combinational from a/b/op)
//             a, b, op - operands/opcode to ULA and display
//             res1_q/res2_q   - latched ULA results
//             valid    - res*_q correspond to the current a/b/op
//             busy     - high during SETTLE and CAPTURE
//  Revision : 1.0 - initial release
// ============================================================================
module ula_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_DIGIT       = 9
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic [7:0] result1,
  input  logic [7:0] result2,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [1:0] op,
  output logic [7:0] res1_q,
  output logic [7:0] res2_q,
  output logic       valid,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]        C_MAX    = 8'(MAX_DIGIT);

  localparam logic [1:0] S_EDIT    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_SHOW    = 2'd3;

  logic [3:0] w_press;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_edit_any;
  logic       w_edit_apply;
  logic       w_capture;

  // --------------------------------------------------------------------------
  // Per-key synchroniser, debouncer and falling-edge detector.
  // The counter only advances while the synced sample disagrees with the
  // accepted level, so any bounce back to the old level restarts it.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      logic             r_level;
      logic             r_level_d;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          r_sync1   <= 1'b1;
          r_sync2   <= 1'b1;
          r_level   <= 1'b1;
          r_level_d <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_sync1   <= KEY[gi];
          r_sync2   <= r_sync1;
          r_level_d <= r_level;
          if (r_sync2 == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // One-cycle pulse on an accepted 1->0 transition only.
      assign w_press[gi] = r_level_d & ~r_level;
    end
  endgenerate

  assign w_edit_any = |w_press[2:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_EDIT;
    else       r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state. An execute press coinciding with an edit press is
  // dropped so the evaluation never sees operands changing underneath it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EDIT: begin
        if (w_press[3] && !w_edit_any) w_state_next = S_SETTLE;
      end
      S_SETTLE:  w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_SHOW;
      S_SHOW: begin
        if (w_edit_any)      w_state_next = S_EDIT;
        else if (w_press[3]) w_state_next = S_SETTLE;
      end
      default:   w_state_next = S_EDIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / datapath controls. Edits are ignored while busy.
  // --------------------------------------------------------------------------
  always_comb begin
    busy         = 1'b0;
    w_edit_apply = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_EDIT:    w_edit_apply = w_edit_any;
      S_SETTLE:  busy = 1'b1;
      S_CAPTURE: begin
        busy      = 1'b1;
        w_capture = 1'b1;
      end
      S_SHOW:    w_edit_apply = w_edit_any;
      default:   busy = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, opcode and result registers. valid drops on the same edge that
  // any operand changes, and rises on the capture edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      a      <= '0;
      b      <= '0;
      op     <= '0;
      res1_q <= '0;
      res2_q <= '0;
      valid  <= 1'b0;
    end else begin
      if (w_edit_apply) begin
        if (w_press[2]) a  <= (a == C_MAX) ? 8'd0 : a + 8'd1;
        if (w_press[1]) b  <= (b == C_MAX) ? 8'd0 : b + 8'd1;
        if (w_press[0]) op <= op + 2'd1;
        valid <= 1'b0;
      end
      if (w_capture) begin
        res1_q <= result1;
        res2_q <= result2;
        valid  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_sequencer
//  Purpose  : Self-checking bench for ula_sequencer with a behavioural model
//             of operands, opcode and latched results, plus a simple ULA.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_sequencer;

  localparam int D    = 4;
  localparam int MAXD = 9;
  localparam int HOLD = D + 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] KEY      = 4'hF;
  logic [7:0] result1, result2;
  logic [7:0] a, b, res1_q, res2_q;
  logic [1:0] op;
  logic       valid, busy;
  logic       force_aa = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int         m_a = 0, m_b = 0, m_op = 0, m_valid = 0;
  logic [7:0] m_r1 = 8'd0, m_r2 = 8'd0;

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] ula1(input int x, input int y, input int o);
    case (o)
      0:       return 8'(x - y);
      1:       return 8'(x + y);
      2:       return 8'(x * y);
      default: return 8'(x ^ y);
    endcase
  endfunction

  function automatic logic [7:0] ula2(input int x, input int y, input int o);
    return 8'((x % 16) * 16 + (y % 16) + o);
  endfunction

  assign result1 = force_aa ? 8'hAA : ula1(int'(a), int'(b), int'(op));
  assign result2 = ula2(int'(a), int'(b), int'(op));

  ula_sequencer #(.DEBOUNCE_CYCLES(D), .MAX_DIGIT(MAXD)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .KEY      (KEY),
    .result1  (result1),
    .result2  (result2),
    .a        (a),
    .b        (b),
    .op       (op),
    .res1_q   (res1_q),
    .res2_q   (res2_q),
    .valid    (valid),
    .busy     (busy)
  );

  // Model of one clean press of the keys in mask.
  task automatic model_press(input logic [3:0] mask);
    if (mask[2:0] != 3'b000) begin
      if (mask[2]) m_a  = (m_a == MAXD) ? 0 : m_a + 1;
      if (mask[1]) m_b  = (m_b == MAXD) ? 0 : m_b + 1;
      if (mask[0]) m_op = (m_op + 1) % 4;
      m_valid = 0;
    end else if (mask[3]) begin
      m_r1    = ula1(m_a, m_b, m_op);
      m_r2    = ula2(m_a, m_b, m_op);
      m_valid = 1;
    end
  endtask

  // Clean press and release of all keys in mask; counts busy cycles seen.
  task automatic press(input logic [3:0] mask, output int busy_cycles);
    busy_cycles = 0;
    KEY = ~mask;
    repeat (HOLD) begin
      @(negedge CLOCK_50);
      if (busy === 1'b1) busy_cycles++;
    end
    KEY = 4'hF;
    repeat (HOLD) begin
      @(negedge CLOCK_50);
      if (busy === 1'b1) busy_cycles++;
    end
    model_press(mask);
  endtask

  task automatic do_reset();
    KEY   = 4'hF;
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_r1 = 8'd0; m_r2 = 8'd0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({a, b, op, res1_q, res2_q, valid, busy} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_state: got a=%0d b=%0d op=%0d r1=%h r2=%h v=%b busy=%b, want all 0",
               a, b, op, res1_q, res2_q, valid, busy);
    end
  endtask

  task automatic test_edit_a();
    int bc;
    repeat (3) press(4'b0100, bc);
    n_cmp++;
    if (a !== 8'(m_a) || b !== 8'd0 || op !== 2'd0 || valid !== 1'b0 || m_a != 3) begin
      n_bad++;
      $display("FAIL edit_a: got a=%0d b=%0d op=%0d v=%b, want a=3 b=0 op=0 v=0", a, b, op, valid);
    end
  endtask

  task automatic test_edit_b_wrap();
    int bc;
    for (int i = 1; i <= 10; i++) begin
      press(4'b0010, bc);
      n_cmp++;
      if (b !== 8'(i % 10)) begin
        n_bad++;
        $display("FAIL b_step%0d: got b=%0d, want %0d", i, b, i % 10);
      end
    end
  endtask

  task automatic test_edit_op_wrap();
    int bc;
    for (int i = 1; i <= 5; i++) begin
      press(4'b0001, bc);
      n_cmp++;
      if (op !== 2'(i % 4)) begin
        n_bad++;
        $display("FAIL op_step%0d: got op=%0d, want %0d", i, op, i % 4);
      end
    end
  endtask

  task automatic test_execute();
    int bc;
    do_reset();
    repeat (4) press(4'b0100, bc);
    repeat (2) press(4'b0010, bc);
    press(4'b0001, bc);
    press(4'b1000, bc);
    n_cmp++;
    if (bc != 2) begin
      n_bad++;
      $display("FAIL exec_busy: got %0d busy cycles, want 2", bc);
    end
    n_cmp++;
    if (res1_q !== 8'h06 || res2_q !== m_r2 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL exec_result: got r1=%h r2=%h v=%b, want r1=06 r2=%h v=1",
               res1_q, res2_q, valid, m_r2);
    end
    press(4'b0100, bc);
    n_cmp++;
    if (a !== 8'd5 || valid !== 1'b0 || bc != 0 || res1_q !== 8'h06) begin
      n_bad++;
      $display("FAIL exec_then_edit: got a=%0d v=%b busy=%0d r1=%h, want a=5 v=0 busy=0 r1=06",
               a, valid, bc, res1_q);
    end
  endtask

  task automatic test_bounce();
    int bc;
    int a0;
    a0 = int'(a);
    for (int i = 0; i < 10; i++) begin
      KEY[2] = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      KEY[2] = 1'b1;
      repeat (2) @(negedge CLOCK_50);
    end
    press(4'b0100, bc);
    n_cmp++;
    if (a !== 8'((a0 == MAXD) ? 0 : a0 + 1)) begin
      n_bad++;
      $display("FAIL bounce: got a=%0d, want %0d", a, (a0 == MAXD) ? 0 : a0 + 1);
    end
  endtask

  task automatic test_exec_with_edit();
    int bc;
    int b0;
    b0 = int'(b);
    press(4'b1010, bc);
    n_cmp++;
    if (b !== 8'((b0 == MAXD) ? 0 : b0 + 1) || bc != 0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL exec_plus_b: got b=%0d busy=%0d v=%b, want b=%0d busy=0 v=0",
               b, bc, valid, (b0 == MAXD) ? 0 : b0 + 1);
    end
  endtask

  task automatic test_random();
    int         bc;
    logic [3:0] mask;
    for (int i = 0; i < 24; i++) begin
      mask = 4'($urandom_range(1, 15));
      if (i % 3 == 0) mask = 4'b1000;
      press(mask, bc);
      n_cmp++;
      if (a !== 8'(m_a) || b !== 8'(m_b) || op !== 2'(m_op) || valid !== 1'(m_valid) ||
          res1_q !== m_r1 || res2_q !== m_r2 ||
          bc != ((mask[2:0] == 3'b000) ? 2 : 0)) begin
        n_bad++;
        $display("FAIL random%0d mask=%b: got a=%0d b=%0d op=%0d v=%b r1=%h r2=%h busy=%0d, want a=%0d b=%0d op=%0d v=%0d r1=%h r2=%h",
                 i, mask, a, b, op, valid, res1_q, res2_q, bc, m_a, m_b, m_op, m_valid, m_r1, m_r2);
      end
    end
  endtask

  task automatic test_reset_in_capture();
    int bc;
    int seen;
    press(4'b0100, bc);
    press(4'b0010, bc);
    KEY[3] = 1'b0;
    seen = 0;
    for (int i = 0; i < 3 * HOLD && seen == 0; i++) begin
      @(negedge CLOCK_50);
      if (busy === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen == 0) begin
      n_bad++;
      $display("FAIL capture_wait: busy never rose, want busy=1");
    end
    // Now in SETTLE; one more cycle puts the FSM in CAPTURE.
    force_aa = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b1;
    KEY   = 4'hF;
    @(negedge CLOCK_50);
    reset = 1'b0;
    force_aa = 1'b0;
    n_cmp++;
    if ({a, b, op, res1_q, res2_q, valid, busy} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_capture: got a=%0d b=%0d op=%0d r1=%h r2=%h v=%b busy=%b, want all 0",
               a, b, op, res1_q, res2_q, valid, busy);
    end
    m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_r1 = 8'd0; m_r2 = 8'd0;
    press(4'b0010, bc);
    n_cmp++;
    if (b !== 8'd1 || bc != 0) begin
      n_bad++;
      $display("FAIL post_reset_edit: got b=%0d busy=%0d, want b=1 busy=0", b, bc);
    end
  endtask

  initial begin
    test_reset();
    test_edit_a();
    test_edit_b_wrap();
    test_edit_op_wrap();
    test_execute();
    test_bounce();
    test_exec_with_edit();
    test_random();
    test_reset_in_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
